// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 digest streamer: widths, FSM states,
// ASCII codes and a known-answer digest.
package sha_pkg;

  localparam int DIGEST_W = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  // SHA-256("abc"), kept here so benches share one reference value
  localparam logic [DIGEST_W-1:0] SHA256_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  function automatic int frame_symbols(input bit hex_mode, input bit append_nl);
    if (!hex_mode)
      return 32;
    return append_nl ? 65 : 64;
  endfunction

endpackage

// File: rtl/sha_digest_tx_if.sv
// Digest capture strobe plus byte-wide valid/ready transmit stream.
interface sha_digest_tx_if;
  import sha_pkg::*;

  logic                digest_valid;
  logic [DIGEST_W-1:0] digest_in;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx_last;
  logic                busy;
  logic                overrun;

  modport master (
    input  digest_valid, digest_in, tx_ready,
    output tx_data, tx_valid, tx_last, busy, overrun
  );

  modport slave (
    output digest_valid, digest_in, tx_ready,
    input  tx_data, tx_valid, tx_last, busy, overrun
  );

endinterface

// File: rtl/sha_hex_nibble.sv
// Combinational nibble to lowercase ASCII hex character.
module sha_hex_nibble
  import sha_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_ZERO + {4'd0, nibble};
    if (nibble > 4'd9)
      ascii = ASCII_A_LC + {4'd0, nibble} - 8'd10;
  end

endmodule

// File: rtl/sha_digest_tx.sv
// Captures a 256-bit digest on a strobe and streams it MSB-first, either as
// raw bytes or as lowercase ASCII hex with an optional trailing newline.
module sha_digest_tx
  import sha_pkg::*;
#(
  parameter bit HEX_MODE  = 1'b0,
  parameter bit APPEND_NL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  sha_digest_tx_if.master bus
);

  localparam int         NSYM     = frame_symbols(HEX_MODE, APPEND_NL);
  localparam logic [6:0] LAST_IDX = 7'(NSYM - 1);
  localparam logic [6:0] NL_IDX   = 7'd64;
  localparam int         STEP     = HEX_MODE ? 4 : 8;

  tx_state_t           state_reg, state_next;
  logic [6:0]          idx_reg, idx_next;
  logic [DIGEST_W-1:0] shift_reg, shift_next;
  logic                overrun_reg, overrun_next;

  logic       sending;
  logic       at_last;
  logic       xfer;
  logic [7:0] hex_char;
  logic [7:0] sym;

  assign sending = (state_reg == ST_SEND);
  assign at_last = (idx_reg == LAST_IDX);
  assign xfer    = sending && bus.tx_ready;

  sha_hex_nibble u_hex_nibble (
    .nibble (shift_reg[DIGEST_W-1 -: 4]),
    .ascii  (hex_char)
  );

  always_comb begin
    sym = shift_reg[DIGEST_W-1 -: 8];
    if (HEX_MODE) begin
      sym = hex_char;
      // The newline slot follows the 64th nibble, when the register is empty
      if (APPEND_NL && idx_reg == NL_IDX)
        sym = ASCII_NL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= 7'd0;
      shift_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    shift_next   = shift_reg;
    overrun_next = overrun_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.digest_valid) begin
          shift_next = bus.digest_in;
          idx_next   = 7'd0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer && at_last) begin
          idx_next = 7'd0;
          // A strobe on the final transfer chains straight into the next frame
          if (bus.digest_valid)
            shift_next = bus.digest_in;
          else
            state_next = ST_IDLE;
        end else begin
          if (bus.digest_valid)
            overrun_next = 1'b1;
          if (xfer) begin
            idx_next   = idx_reg + 7'd1;
            shift_next = shift_reg << STEP;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 7'd0;
      end
    endcase
  end

  assign bus.tx_valid = sending;
  assign bus.busy     = sending;
  assign bus.tx_last  = sending && at_last;
  assign bus.tx_data  = sending ? sym : 8'h00;
  assign bus.overrun  = overrun_reg;

endmodule

// File: doc/sha_digest_tx.md
# sha_digest_tx

Output-side streamer for the SHA-256 core: captures the 256-bit `Hash_Digest` on a one-cycle completion strobe and transmits it byte-serially over a valid/ready stream, most-significant byte first. It is the transmit mirror of the core's byte-wide input path (`data_in` / `byte_rdy` / `byte_stop`). Optionally it emits the digest as 64 lowercase ASCII hex characters plus a trailing newline, for direct use by a UART bridge.

## Interface
- `HEX_MODE`, 0: 0 sends 32 raw bytes; 1 sends 64 ASCII hex characters.
- `APPEND_NL`, 0: when `HEX_MODE`=1, append 0x0A as a 65th symbol. Ignored when `HEX_MODE`=0.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `digest_valid` in 1: single-cycle strobe; `digest_in` is valid in this cycle.
- `digest_in` in 256: digest word; [255:248] is the first byte.
- `tx_data` out 8: current symbol.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the symbol; transfer = `tx_valid & tx_ready`.
- `tx_last` out 1: high with the final symbol of a frame.
- `busy` out 1: a frame is in progress.
- `overrun` out 1: sticky; a digest was dropped.

## Operation
- Symbols per frame, NSYM: 32 (raw), 64 (hex), 65 (hex + NL). 7-bit symbol counter `idx`.
- FSM states:
  - IDLE: `busy`=0, `tx_valid`=0. On `digest_valid`, load the 256-bit shift register, set `idx`=0, go to SEND.
  - SEND: `tx_valid`=1. On each transfer, `idx`++; the shift register advances by 8 bits (raw) or 4 bits (hex) per symbol.
    - On a transfer with `idx`=NSYM-1, return to IDLE, unless `digest_valid` is high in the same cycle. In that case reload and stay in SEND (back-to-back frames, no bubble).
- Symbol value:
  - Raw mode: top byte of the shift register.
  - Hex mode: ASCII of the top nibble. 0–9 map to 0x30–0x39; a–f map to 0x61–0x66.
  - NL symbol: 0x0A.
- `tx_last` = SEND && `idx`==NSYM-1.
- Overrun: `digest_valid` in SEND other than on the final-transfer cycle sets `overrun`. The new digest is discarded and the current frame continues unaffected. `overrun` clears only on reset.
- `busy` = (state==SEND).

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `overrun`=0, state IDLE, `idx`=0.
- Latency: `digest_valid` at edge N gives `tx_valid`=1 with the first symbol from N+1.
- While `tx_valid` && !`tx_ready`, `tx_data` and `tx_last` are held stable. `tx_valid` never drops mid-frame.
- Throughput: one symbol per cycle with `tx_ready` held high. A raw frame takes 32 cycles; a hex frame takes 64 or 65.
- Reset asserted mid-frame: the frame aborts. The next cycle shows `tx_valid`=0, and no partial remainder is ever emitted.
- `digest_valid` in IDLE and reset in the same cycle: reset wins.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `tx_ready` or `digest_valid` to outputs.

## Structure
- Shared package `sha_pkg` holds:
  - `DIGEST_W`=256
  - FSM state typedef (IDLE, SEND)
  - ASCII constants (0x30, 0x61, 0x0A)
  - `SHA256_ABC` digest constant, ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, for benches
- One sub-module, `sha_hex_nibble`: 4-bit in, 8-bit ASCII out, purely combinational.

## Test plan
- Raw mode, `SHA256_ABC` strobe, `tx_ready`=1:
  - 32 transfers on consecutive cycles starting N+1: 0xBA, 0x78, 0x16, …, 0x15, 0xAD.
  - `tx_last` only on 0xAD; `busy` falls afterwards.
- HEX_MODE=1, APPEND_NL=1, same digest:
  - 65 symbols: 0x62 'b', 0x61 'a', 0x37, 0x38, …, 0x61, 0x64, then 0x0A with `tx_last`.
- Backpressure, raw mode:
  - Stimulus: random `tx_ready` (≈40% duty).
  - Required: `tx_data` stable while stalled, byte sequence identical to the first scenario, exactly 32 transfers.
- Overrun:
  - Stimulus: second `digest_valid` (all 0xFF) at transfer 10.
  - Required: `overrun`=1, frame 1 completes unaltered, no 0xFF bytes emitted, IDLE afterwards.
- Back-to-back:
  - Stimulus: second digest (all 0x00) strobed on the cycle of the final transfer.
  - Required: next cycle `tx_valid`=1 with 0x00, 64 transfers total, `overrun`=0.
- Reset mid-frame:
  - Stimulus: `rst`=0 at transfer 5, release, then a new strobe.
  - Required: during reset `tx_valid`=0 and all outputs at reset values; the new frame starts from byte 0.
